bus_uart_tx: RTL and testbench
==============================

BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameters: BASE_ADDR, default 32'h1000_0000, word-aligned base of the register window; FIFO_DEPTH, default 8, TX FIFO entries, a power of 2 from 2 to 16; DEFAULT_DIV, default 16'd433, reset value of the baud divisor.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clock  input  1  single clock; all state on rising edge
  reset  input  1  asynchronous, active-low
  address  input  32  data bus byte address
  write_data  input  32  data bus write data
  byte_enable  input  4  byte lanes of write_data
  read_enable  input  1  bus read strobe
  write_enable  input  1  bus write strobe
  read_data  output  32  register read data
  uart_tx  output  1  serial line, idle high

Function
REQ-003 SHALL select the block when address[31:4] == BASE_ADDR[31:4]; offset = address[3:2].
REQ-004 SHALL drive read_data combinationally in the same cycle (zero wait states); read_data = 0 when not selected or read_enable = 0.
REQ-005 SHALL decode offset 0 as TXDATA: a write with byte_enable[0] = 1 pushes write_data[7:0]; a read returns 0.
REQ-006 SHALL decode offset 1 as STATUS: read {23'b0, count[4:0], overflow, busy, empty, full} in bits [8:0]; a write with write_data[3] = 1 clears overflow (write-1-to-clear).
REQ-007 SHALL decode offset 2 as BAUDDIV: read {16'b0, div}; a write with byte_enable[1:0] = 2'b11 loads div = write_data[15:0].
REQ-008 SHALL decode offset 3 as reserved: reads return 0 and writes are ignored.
REQ-009 SHALL accept a push when the FIFO is not full, or when a pop occurs in the same cycle; otherwise it SHALL drop the byte and set overflow (sticky).
REQ-010 SHALL run a transmit FSM with states IDLE, START, DATA, STOP; IDLE -> START when the FIFO is not empty, popping the head into the shift register on that transition.
REQ-011 SHALL hold each bit for div+1 clocks; div = 0 gives 1 clock per bit.
REQ-012 SHALL drive uart_tx to 0 in START, to data bits LSB first in DATA (8 bits, counted by a 3-bit index), and to 1 in STOP and IDLE.
REQ-013 SHALL go from STOP to START with a pop if the FIFO is not empty (back-to-back frames, no idle gap); otherwise STOP -> IDLE.
REQ-014 SHALL apply a BAUDDIV write during a frame at the next bit boundary; the current bit completes with the old count.
REQ-015 SHALL assert busy whenever the state is not IDLE.
REQ-016 SHALL let a simultaneous STATUS clear and overflow set leave overflow = 1.

Reset
REQ-017 SHALL, while reset = 0, asynchronously force: state = IDLE, uart_tx = 1, FIFO empty (count 0), overflow = 0, div = DEFAULT_DIV, bit counter = 0, baud counter = 0.
REQ-018 SHALL abort a frame in progress when reset is asserted mid-frame; uart_tx returns to 1 immediately and the partial frame is not resumed.

Configuration
REQ-019 SHALL, when UART_TX_PARITY_EN is defined, add a PARITY state between DATA and STOP that sends even parity (XOR of the 8 data bits), giving 11 bits per frame.
REQ-020 SHALL, when UART_TX_PARITY_EN is not defined, omit the PARITY state and use 10-bit frames.

Structure
REQ-021 SHALL place the register offsets, STATUS bit positions and the FSM state enum in the shared package bus_periph_pkg.
REQ-022 SHALL implement the FIFO as the sub-module uart_tx_fifo (synchronous FIFO with push, pop, full, empty, count).

Verification
REQ-023 SHALL cover: div = 1, write 0x55 to TXDATA -> uart_tx is 0 for 2 clocks, then 1,0,1,0,1,0,1,0 at 2 clocks each, then 1 for 2 clocks; busy = 1 throughout; total 20 clocks.
REQ-024 SHALL cover: with the shifter busy, 9 writes at depth 8 -> first 8 bytes accepted, 9th dropped, STATUS reads full = 1, overflow = 1; then writing STATUS with 0x8 -> overflow = 0.
REQ-025 SHALL cover: div = 0, write 0xA1 then 0x3C -> two frames back-to-back with no idle-high gap between the first stop bit and the second start bit.
REQ-026 SHALL cover: a BAUDDIV write of 3 in the middle of a bit while div = 1 -> that bit lasts 2 clocks, later bits last 4 clocks.
REQ-027 SHALL cover: reset asserted during data bit 3 -> uart_tx = 1 in the same cycle, STATUS = 0x2 (empty), BAUDDIV reads DEFAULT_DIV.
REQ-028 SHALL cover: a read of address BASE_ADDR+0x10 and a read with read_enable = 0 -> read_data = 0; with UART_TX_PARITY_EN defined, 0x07 sends parity 1.

Source files
------------

// File: rtl/bus_periph_pkg.sv
// Shared register map, STATUS bit positions and UART TX state encoding.
// Defining UART_TX_PARITY_EN adds the PARITY state and the even-parity helper is then used.
package bus_periph_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO feeding the UART shifter.
// DEPTH must be a power of two between 2 and 16 so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          pop_en_s, push_en_s;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == 5'd0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it.
  assign pop_en_s  = pop & ~empty;
  assign push_en_s = push & (~full | pop_en_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push_en_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached UART transmitter: zero-wait register window, TX FIFO and framing FSM.
// Define UART_TX_PARITY_EN for 11-bit frames with an even parity bit.
module bus_uart_tx
  import bus_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        read_enable,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic        uart_tx
);

  logic        sel_s, busy_s, bit_done_s;
  logic [1:0]  offset_s;
  logic        push_req_s, push_ok_s, pop_s;
  logic        ovf_set_s, ovf_clr_s, div_wr_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [4:0]  fifo_count_s;
  logic [7:0]  fifo_head_s;
  logic [31:0] status_s;
  logic        unused_bits_s;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;

  assign sel_s      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset_s   = address[3:2];
  assign push_req_s = write_enable & sel_s & (offset_s == OFF_TXDATA) & byte_enable[0];
  assign push_ok_s  = push_req_s & (~fifo_full_s | pop_s);
  assign ovf_set_s  = push_req_s & ~push_ok_s;
  assign ovf_clr_s  = write_enable & sel_s & (offset_s == OFF_STATUS) & write_data[STAT_OVF];
  assign div_wr_s   = write_enable & sel_s & (offset_s == OFF_BAUDDIV) & (byte_enable[1:0] == 2'b11);
  assign busy_s     = (state_q != ST_IDLE);
  assign bit_done_s = (baud_q == bit_div_q);
  assign uart_tx    = tx_q;

  assign unused_bits_s = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_ok_s),
    .push_data(write_data[7:0]),
    .pop      (pop_s),
    .pop_data (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Control registers: sticky overflow (set wins over clear) and baud divisor.
  always_comb begin
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    div_d = div_wr_s ? write_data[15:0] : div_q;
  end

  // Frame FSM; tx_d is the line level for the state being entered so uart_tx is a flop.
  // The divisor is latched per bit, so a BAUDDIV write only affects the next bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = bit_done_s ? 16'd0 : baud_q + 16'd1;
    bit_div_d = bit_done_s ? div_d : bit_div_q;
    tx_d      = 1'b1;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d    = 16'd0;
        bit_div_d = div_d;
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_d   = fifo_head_s;
          bit_idx_d = 3'd0;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done_s) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_done_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          tx_d    = even_parity(shift_q);
`else
          state_d = ST_STOP;
          tx_d    = 1'b1;
`endif
        end else if (bit_done_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
          tx_d      = shift_q[bit_idx_d];
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = even_parity(shift_q);
        if (bit_done_s) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done_s && !fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_d   = fifo_head_s;
          bit_idx_d = 3'd0;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end else if (bit_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = 16'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      baud_q    <= 16'd0;
      bit_div_q <= DEFAULT_DIV;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      bit_div_q <= bit_div_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    status_s                       = 32'd0;
    status_s[STAT_FULL]            = fifo_full_s;
    status_s[STAT_EMPTY]           = fifo_empty_s;
    status_s[STAT_BUSY]            = busy_s;
    status_s[STAT_OVF]             = ovf_q;
    status_s[STAT_COUNT +: 5]      = fifo_count_s;
    read_data                      = 32'd0;
    if (sel_s && read_enable) begin
      case (offset_s)
        OFF_STATUS:  read_data = status_s;
        OFF_BAUDDIV: read_data = {16'd0, div_q};
        default:     read_data = 32'd0;
      endcase
    end else begin
      read_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed register/boundary cases plus random frames
// compared against a bit-level frame model built from the framing rules.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [15:0] DEF_DIV = 16'd433;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] A_TX    = BASE;
  localparam logic [31:0] A_ST    = BASE + 32'h4;
  localparam logic [31:0] A_BD    = BASE + 32'h8;
  localparam logic [31:0] A_RS    = BASE + 32'hC;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, write_data, read_data;
  logic [3:0]  byte_enable;
  logic        read_enable, write_enable, uart_tx;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          rec_en = 1'b0;
  bit          line_q[$];
  logic [31:0] stat_q[$];
  bit          exp_q[$];

  always #5 clock = ~clock;

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .write_data  (write_data),
    .byte_enable (byte_enable),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .read_data   (read_data),
    .uart_tx     (uart_tx)
  );

  // Line and bus read-data recorder, sampled mid-cycle.
  always @(negedge clock) begin
    if (rec_en) begin
      line_q.push_back(uart_tx);
      stat_q.push_back(read_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    address      = a;
    write_data   = d;
    byte_enable  = be;
    write_enable = 1'b1;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address     = a;
    read_enable = 1'b1;
    @(negedge clock);
    d = read_data;
    @(posedge clock);
    #1;
    read_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic start_rec();
    line_q.delete();
    stat_q.delete();
    exp_q.delete();
    rec_en = 1'b1;
  endtask

  // Frame model: start 0, data LSB first, optional even parity, stop 1.
  // The first n_a bits last div_a+1 clocks, the rest div_b+1 clocks.
  task automatic add_frame(input logic [7:0] b, input int div_a, input int n_a, input int div_b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      repeat (((j < n_a) ? div_a : div_b) + 1) exp_q.push_back(bits[j]);
    end
  endtask

  // Compare the recorded line from its first low sample with the model, then require idle-high.
  task automatic check_stream(input string tag, input bit busy_chk);
    int s, n, bad, nb;
    logic [255:0] got, exp;
    s = -1;
    for (int i = 0; i < line_q.size(); i++) if (s < 0 && line_q[i] == 1'b0) s = i;
    check_eq({tag, "_start_seen"}, (s >= 0), 1'b1);
    if (s < 0) s = 0;
    n = exp_q.size();
    got = 256'd0;
    exp = 256'd0;
    bad = 0;
    nb  = 0;
    for (int i = 0; i < n; i++) begin
      exp[i] = exp_q[i];
      got[i] = (s + i < line_q.size()) ? line_q[s + i] : 1'bx;
      if (s + i < stat_q.size() && stat_q[s + i][2] == 1'b1) nb++;
    end
    check_eq({tag, "_wave"}, got, exp);
    for (int i = s + n; i < line_q.size(); i++) if (line_q[i] != 1'b1) bad++;
    check_eq({tag, "_tail_idle"}, bad, 0);
    if (busy_chk) begin
      check_eq({tag, "_busy_cycles"}, nb, n);
      check_eq({tag, "_busy_after"}, (s + n < stat_q.size()) ? stat_q[s + n][2] : 1'bx, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          dv, k, zeros;

    reset        = 1'b0;
    address      = 32'd0;
    write_data   = 32'd0;
    byte_enable  = 4'd0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    idle(3);
    check_eq("rst_line", uart_tx, 1'b1);
    reset = 1'b1;
    idle(1);

    // Reset values and address decode.
    bus_read(A_ST, d);                 check_eq("rst_status", d, 32'h2);
    bus_read(A_BD, d);                 check_eq("rst_div", d, {16'd0, DEF_DIV});
    bus_read(A_TX, d);                 check_eq("txdata_read", d, 32'd0);
    bus_read(A_RS, d);                 check_eq("rsvd_read", d, 32'd0);
    bus_read(BASE + 32'h10, d);        check_eq("unsel_read_10", d, 32'd0);
    bus_read(BASE + 32'h14, d);        check_eq("unsel_read_14", d, 32'd0);
    address = A_ST;
    read_enable = 1'b0;
    @(negedge clock);
    check_eq("no_read_enable", read_data, 32'd0);
    idle(1);
    bus_write(A_RS, 32'hFFFF_FFFF, 4'hF);
    bus_write(BASE + 32'h18, 32'h5, 4'hF);
    bus_read(A_BD, d);                 check_eq("ignored_writes_div", d, {16'd0, DEF_DIV});
    bus_read(A_ST, d);                 check_eq("ignored_writes_status", d, 32'h2);

    // div = 1, single 0x55 frame, busy throughout, idle right after.
    bus_write(A_BD, 32'd1, 4'hF);
    start_rec();
    bus_write(A_TX, 32'h55, 4'h1);
    address = A_ST;
    read_enable = 1'b1;
    idle(30);
    read_enable = 1'b0;
    rec_en = 1'b0;
    add_frame(8'h55, 1, 0, 1);
    check_stream("frame_55", 1'b1);

    // div = 0, back-to-back frames without an idle gap.
    bus_write(A_BD, 32'd0, 4'hF);
    start_rec();
    bus_write(A_TX, 32'hA1, 4'h1);
    bus_write(A_TX, 32'h3C, 4'h1);
    idle(30);
    rec_en = 1'b0;
    add_frame(8'hA1, 0, 0, 0);
    add_frame(8'h3C, 0, 0, 0);
    check_stream("b2b", 1'b0);

    // Parity-sensitive byte (odd number of ones).
    start_rec();
    bus_write(A_TX, 32'h07, 4'h1);
    idle(20);
    rec_en = 1'b0;
    add_frame(8'h07, 0, 0, 0);
    check_stream("frame_07", 1'b0);

    // Divisor change written mid data bit 0: that bit keeps 2 clocks, later bits take 4.
    bus_write(A_BD, 32'd1, 4'hF);
    start_rec();
    bus_write(A_TX, 32'h96, 4'h1);
    idle(3);
    bus_write(A_BD, 32'd3, 4'h3);
    idle(60);
    rec_en = 1'b0;
    add_frame(8'h96, 1, 2, 3);
    check_stream("div_change", 1'b0);
    bus_read(A_BD, d);                 check_eq("div_now_3", d, 32'd3);

    // Overflow with the shifter busy.
    bus_write(A_BD, 32'd20, 4'hF);
    bus_write(A_TX, 32'hAA, 4'h1);
    idle(2);
    for (int i = 0; i < DEPTH; i++) bus_write(A_TX, i, 4'h1);
    bus_read(A_ST, d);
    check_eq("fill_status", d, (DEPTH << 4) | 32'h5);
    bus_write(A_TX, 32'hEE, 4'h1);
    bus_read(A_ST, d);
    check_eq("ovf_full_bit", d[0], 1'b1);
    check_eq("ovf_bit", d[3], 1'b1);
    check_eq("ovf_status", d, (DEPTH << 4) | 32'hD);
    bus_write(A_ST, 32'h0, 4'hF);
    bus_read(A_ST, d);                 check_eq("ovf_sticky", d[3], 1'b1);
    bus_write(A_ST, 32'h8, 4'hF);
    bus_read(A_ST, d);
    check_eq("ovf_cleared", d[3], 1'b0);
    check_eq("ovf_cleared_status", d, (DEPTH << 4) | 32'h5);
    do_reset();

    // Reset asserted during data bit 3 aborts the frame at once.
    bus_write(A_BD, 32'd1, 4'hF);
    bus_write(A_TX, 32'h00, 4'h1);
    idle(9);
    #2;
    check_eq("abort_pre_low", uart_tx, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("abort_line_high", uart_tx, 1'b1);
    idle(2);
    reset = 1'b1;
    bus_read(A_ST, d);                 check_eq("abort_status", d, 32'h2);
    bus_read(A_BD, d);                 check_eq("abort_div", d, {16'd0, DEF_DIV});
    bus_write(A_BD, 32'd1, 4'hF);
    start_rec();
    idle(40);
    rec_en = 1'b0;
    zeros = 0;
    for (int i = 0; i < line_q.size(); i++) if (line_q[i] == 1'b0) zeros++;
    check_eq("abort_no_resume", zeros, 0);

    // Random frames, including writes that must be ignored by byte-enable rules.
    for (int it = 0; it < 8; it++) begin
      dv = $urandom_range(0, 3);
      bus_write(A_BD, dv, 4'hF);
      bus_write(A_BD, 32'h0000_7777, 4'b0001);
      bus_write(A_BD, 32'h0000_7777, 4'b1110);
      bus_read(A_BD, d);
      check_eq("rnd_div", d, dv);
      start_rec();
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        bus_write(A_TX, {24'($urandom), b}, {3'($urandom), 1'b1});
        add_frame(b, dv, 0, dv);
        if ($urandom_range(0, 1) == 1) bus_write(A_TX, 32'($urandom), 4'b1110);
      end
      idle(k * 11 * (dv + 1) + 12);
      rec_en = 1'b0;
      check_stream("rnd", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
